// File: rtl/fractal_sync_cam_rf.sv
// ---------------------------------------------------------------------------
// fractal_sync_cam_rf
//
// Multi-port content-addressable barrier register file. Each CAM line holds
// one barrier signature that has seen its first arrival. A later arrival of
// the same signature reports "present" (barrier complete) and frees the line.
// Lookups are combinational against the line state registered at the start of
// the cycle; every state change lands on the next rising clock edge.
//
// Ports:
//   clk_i           clock
//   rst_ni          asynchronous active-low reset
//   check_i[p]      port p requests a lookup this cycle
//   sig_i[p]        local barrier signature of port p
//   sig_valid_i[p]  signature is legal; an illegal request is ignored
//   clear_i         synchronous flush of all lines and the sticky error
//   present_o[p]    signature already seen (barrier complete), same cycle
//   overflow_o[p]   request missed and no line could be granted, same cycle
//   full_o          every line valid (registered)
//   empty_o         no line valid (registered)
//   occupancy_o     number of valid lines (registered)
//   overflow_err_o  sticky overflow flag, cleared by reset or clear_i
// ---------------------------------------------------------------------------
module fractal_sync_cam_rf #(
    parameter  int N_LINES   = 2,
    parameter  int SIG_WIDTH = 1,
    parameter  int N_PORTS   = 2,
    localparam int CNT_WIDTH = $clog2(N_LINES + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 check_i     [N_PORTS],
    input  logic [SIG_WIDTH-1:0] sig_i       [N_PORTS],
    input  logic                 sig_valid_i [N_PORTS],
    input  logic                 clear_i,
    output logic                 present_o   [N_PORTS],
    output logic                 overflow_o  [N_PORTS],
    output logic                 full_o,
    output logic                 empty_o,
    output logic [CNT_WIDTH-1:0] occupancy_o,
    output logic                 overflow_err_o
);

    // Line state and status registers
    logic [N_LINES-1:0]   valid_q;
    logic [N_LINES-1:0]   valid_d;
    logic [SIG_WIDTH-1:0] sig_q [N_LINES];
    logic [SIG_WIDTH-1:0] sig_d [N_LINES];
    logic [CNT_WIDTH-1:0] occ_q;
    logic [CNT_WIDTH-1:0] occ_d;
    logic                 err_q;
    logic                 err_d;

    // Per-port request decode
    logic [N_PORTS-1:0]   active;
    logic [N_PORTS-1:0]   hit_any;
    logic [N_PORTS-1:0]   dup_lower;
    logic [N_PORTS-1:0]   dup_higher;
    logic [N_LINES-1:0]   match [N_PORTS];

    // Allocation scratch
    logic [N_LINES-1:0]   taken;
    logic                 found;

    // Request decode. A port is active only when it checks with a legal
    // signature. Matches are masked by the line valid bits so an
    // uninitialised or freed line can never produce a hit. The duplicate
    // flags relate each active port to other active ports carrying the same
    // signature in this cycle; only the lowest-index port of such a group
    // touches the CAM.
    always_comb begin
        active     = '0;
        hit_any    = '0;
        dup_lower  = '0;
        dup_higher = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            match[p] = '0;
        end
        for (int p = 0; p < N_PORTS; p++) begin
            active[p] = check_i[p] & sig_valid_i[p];
        end
        for (int p = 0; p < N_PORTS; p++) begin
            for (int l = 0; l < N_LINES; l++) begin
                match[p][l] = active[p] & valid_q[l] & (sig_q[l] == sig_i[p]);
            end
            hit_any[p] = |match[p];
        end
        for (int p = 0; p < N_PORTS; p++) begin
            for (int q = 0; q < N_PORTS; q++) begin
                if (active[p] && active[q] && (sig_i[q] == sig_i[p])) begin
                    if (q < p) begin
                        dup_lower[p] = 1'b1;
                    end
                    if (q > p) begin
                        dup_higher[p] = 1'b1;
                    end
                end
            end
        end
    end

    // Lookup results and next-state computation.
    // Ports are walked in index order so lower ports win free lines. Free
    // lines come from the pre-edge valid mask, so a line freed by a hit this
    // cycle cannot be handed out before the next cycle.
    // A signature that misses in the CAM but arrives on two ports in the same
    // cycle completes its barrier immediately: the higher ports report
    // present, and the lowest port neither allocates nor competes for a line,
    // so it cannot overflow either.
    // clear_i overrides every update, but the same-cycle present/overflow
    // outputs still describe the pre-clear contents.
    always_comb begin
        valid_d = valid_q;
        sig_d   = sig_q;
        occ_d   = occ_q;
        err_d   = err_q;
        taken   = '0;
        found   = 1'b0;
        for (int p = 0; p < N_PORTS; p++) begin
            present_o[p]  = 1'b0;
            overflow_o[p] = 1'b0;
        end

        for (int p = 0; p < N_PORTS; p++) begin
            if (active[p]) begin
                if (hit_any[p] || dup_lower[p]) begin
                    present_o[p] = 1'b1;
                end
                if (hit_any[p] && !dup_lower[p]) begin
                    for (int l = 0; l < N_LINES; l++) begin
                        if (match[p][l]) begin
                            valid_d[l] = 1'b0;
                            occ_d      = occ_d - CNT_WIDTH'(1);
                        end
                    end
                end else if (!hit_any[p] && !dup_lower[p] && !dup_higher[p]) begin
                    found = 1'b0;
                    for (int l = 0; l < N_LINES; l++) begin
                        if (!found && !valid_q[l] && !taken[l]) begin
                            found      = 1'b1;
                            taken[l]   = 1'b1;
                            valid_d[l] = 1'b1;
                            sig_d[l]   = sig_i[p];
                            occ_d      = occ_d + CNT_WIDTH'(1);
                        end
                    end
                    if (!found) begin
                        overflow_o[p] = 1'b1;
                        err_d         = 1'b1;
                    end
                end
            end
        end

        if (clear_i) begin
            valid_d = '0;
            occ_d   = '0;
            err_d   = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            for (int l = 0; l < N_LINES; l++) begin
                sig_q[l] <= '0;
            end
            occ_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            sig_q   <= sig_d;
            occ_q   <= occ_d;
            err_q   <= err_d;
        end
    end

    // Status outputs come straight from registers, so they have no
    // combinational path from the request inputs.
    assign occupancy_o    = occ_q;
    assign full_o         = (occ_q == CNT_WIDTH'(N_LINES));
    assign empty_o        = (occ_q == '0);
    assign overflow_err_o = err_q;

endmodule

// File: tb/tb_fractal_sync_cam_rf.sv
// ---------------------------------------------------------------------------
// tb_fractal_sync_cam_rf
//
// Self-checking bench for fractal_sync_cam_rf (2 lines, 2-bit signatures,
// 2 ports). The reference model keeps the set of stored signatures as a bit
// per signature value plus a sticky error bit. Line placement is invisible at
// the ports, so the model tracks only which signatures are stored. Directed
// scenarios pin literal values, and a random phase follows.
// ---------------------------------------------------------------------------
module tb_fractal_sync_cam_rf;

    localparam int NL   = 2;
    localparam int SW   = 2;
    localparam int NP   = 2;
    localparam int CW   = $clog2(NL + 1);
    localparam int NSIG = 1 << SW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          check     [NP];
    logic [SW-1:0] sig       [NP];
    logic          sig_valid [NP];
    logic          clear;
    logic          present   [NP];
    logic          overflow  [NP];
    logic          full;
    logic          empty;
    logic [CW-1:0] occupancy;
    logic          overflow_err;

    int checks   = 0;
    int failures = 0;

    // Reference state: one bit per signature value that is currently stored
    logic [NSIG-1:0] m_stored = '0;
    logic            m_err    = 1'b0;

    fractal_sync_cam_rf #(
        .N_LINES  (NL),
        .SIG_WIDTH(SW),
        .N_PORTS  (NP)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .check_i       (check),
        .sig_i         (sig),
        .sig_valid_i   (sig_valid),
        .clear_i       (clear),
        .present_o     (present),
        .overflow_o    (overflow),
        .full_o        (full),
        .empty_o       (empty),
        .occupancy_o   (occupancy),
        .overflow_err_o(overflow_err)
    );

    always #5 clk = ~clk;

    // One comparison: counts it and reports a failure with both values
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle worth of request inputs
    task automatic applyStimulus(input bit c0, input int s0, input bit v0,
                                 input bit c1, input int s1, input bit v1,
                                 input bit clr);
        check[0]     = c0;
        sig[0]       = s0[SW-1:0];
        sig_valid[0] = v0;
        check[1]     = c1;
        sig[1]       = s1[SW-1:0];
        sig_valid[1] = v1;
        clear        = clr;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 0, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Barrier rules on the set of stored signatures: the first arrival of a
    // signature in a cycle either completes a stored barrier, pairs with a
    // later same-cycle arrival, takes one of the free lines, or overflows.
    // Any later arrival of that signature in the same cycle reports present.
    function automatic void modelEval(output logic [NP-1:0] ep, output logic [NP-1:0] eo,
                                      output logic [NSIG-1:0] ns, output logic ne);
        logic [NSIG-1:0] seen;
        int              avail;
        int              s;
        bit              later;
        ep    = '0;
        eo    = '0;
        ns    = m_stored;
        ne    = m_err;
        seen  = '0;
        avail = NL - $countones(m_stored);
        for (int p = 0; p < NP; p++) begin
            if (check[p] && sig_valid[p]) begin
                s = int'(sig[p]);
                if (seen[s]) begin
                    ep[p] = 1'b1;
                end else begin
                    seen[s] = 1'b1;
                    later   = 1'b0;
                    for (int q = p + 1; q < NP; q++) begin
                        if (check[q] && sig_valid[q] && sig[q] == sig[p]) later = 1'b1;
                    end
                    if (m_stored[s]) begin
                        ep[p] = 1'b1;
                        ns[s] = 1'b0;
                    end else if (later) begin
                        ns[s] = 1'b0;
                    end else if (avail > 0) begin
                        avail--;
                        ns[s] = 1'b1;
                    end else begin
                        eo[p] = 1'b1;
                        ne    = 1'b1;
                    end
                end
            end
        end
        if (clear) begin
            ns = '0;
            ne = 1'b0;
        end
    endfunction

    // Model state advances on the same edge as the DUT and resets with it
    always @(posedge clk or negedge rst_n) begin : model_update
        logic [NP-1:0]   ep;
        logic [NP-1:0]   eo;
        logic [NSIG-1:0] ns;
        logic            ne;
        if (!rst_n) begin
            m_stored <= '0;
            m_err    <= 1'b0;
        end else begin
            modelEval(ep, eo, ns, ne);
            m_stored <= ns;
            m_err    <= ne;
        end
    end

    // Every falling edge: compare all outputs against the model and check
    // that no two valid lines hold the same signature
    always @(negedge clk) begin : compare
        logic [NP-1:0]   ep;
        logic [NP-1:0]   eo;
        logic [NSIG-1:0] ns;
        logic            ne;
        int              occ;
        int              dupl;
        modelEval(ep, eo, ns, ne);
        occ = $countones(m_stored);
        for (int p = 0; p < NP; p++) begin
            checkOutput($sformatf("model_present%0d", p), int'(present[p]), int'(ep[p]));
            checkOutput($sformatf("model_overflow%0d", p), int'(overflow[p]), int'(eo[p]));
        end
        checkOutput("model_occupancy", int'(occupancy), occ);
        checkOutput("model_full", int'(full), int'(occ == NL));
        checkOutput("model_empty", int'(empty), int'(occ == 0));
        checkOutput("model_overflow_err", int'(overflow_err), int'(m_err));
        dupl = 0;
        for (int a = 0; a < NL; a++) begin
            for (int b = a + 1; b < NL; b++) begin
                if (dut.valid_q[a] && dut.valid_q[b] && dut.sig_q[a] == dut.sig_q[b]) dupl++;
            end
        end
        checkOutput("no_duplicate_lines", dupl, 0);
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        idle();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_occupancy", int'(occupancy), 0);
        checkOutput("reset_empty", int'(empty), 1);
        checkOutput("reset_full", int'(full), 0);
        checkOutput("reset_err", int'(overflow_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        nextCycle();

        // Two arrivals of signature 3
        $display("[TB] two arrivals");
        applyStimulus(1'b1, 3, 1'b1, 1'b0, 0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t1_present0", int'(present[0]), 0);
        nextCycle();
        applyStimulus(1'b0, 0, 1'b1, 1'b1, 3, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t1_occ_after_first", int'(occupancy), 1);
        checkOutput("t1_present1", int'(present[1]), 1);
        nextCycle();
        idle();
        @(negedge clk);
        checkOutput("t1_occ_after_second", int'(occupancy), 0);
        checkOutput("t1_empty", int'(empty), 1);

        // Fill and overflow
        $display("[TB] fill and overflow");
        nextCycle();
        applyStimulus(1'b1, 1, 1'b1, 1'b0, 0, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 2, 1'b1, 1'b0, 0, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 0, 1'b1, 1'b0, 0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t2_full", int'(full), 1);
        checkOutput("t2_overflow0", int'(overflow[0]), 1);
        checkOutput("t2_err_same_cycle", int'(overflow_err), 0);
        nextCycle();
        idle();
        @(negedge clk);
        checkOutput("t2_err_next", int'(overflow_err), 1);
        checkOutput("t2_occ", int'(occupancy), 2);

        // Hit and miss together on a full CAM holding 1 and 2
        $display("[TB] hit plus miss on full");
        nextCycle();
        applyStimulus(1'b1, 1, 1'b1, 1'b1, 3, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t5_present0", int'(present[0]), 1);
        checkOutput("t5_overflow1", int'(overflow[1]), 1);
        nextCycle();
        applyStimulus(1'b1, 3, 1'b1, 1'b0, 0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t5_occ_mid", int'(occupancy), 1);
        checkOutput("t5_retry_overflow", int'(overflow[0]), 0);
        checkOutput("t5_retry_present", int'(present[0]), 0);
        nextCycle();
        idle();
        @(negedge clk);
        checkOutput("t5_occ_end", int'(occupancy), 2);

        // Clear with two valid lines and the sticky error set
        $display("[TB] clear");
        nextCycle();
        applyStimulus(1'b0, 0, 1'b1, 1'b0, 0, 1'b1, 1'b1);
        nextCycle();
        idle();
        @(negedge clk);
        checkOutput("clr_occ", int'(occupancy), 0);
        checkOutput("clr_err", int'(overflow_err), 0);
        checkOutput("clr_empty", int'(empty), 1);

        // Two simultaneous misses
        $display("[TB] simultaneous misses");
        nextCycle();
        applyStimulus(1'b1, 1, 1'b1, 1'b1, 2, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t3_overflow0", int'(overflow[0]), 0);
        checkOutput("t3_overflow1", int'(overflow[1]), 0);
        nextCycle();
        applyStimulus(1'b0, 0, 1'b1, 1'b0, 0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("t3_occ", int'(occupancy), 2);
        checkOutput("t3_full", int'(full), 1);
        nextCycle();

        // Duplicate signature in one cycle, CAM empty
        $display("[TB] same-cycle duplicate");
        applyStimulus(1'b1, 2, 1'b1, 1'b1, 2, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t4_present0", int'(present[0]), 0);
        checkOutput("t4_present1", int'(present[1]), 1);
        nextCycle();
        idle();
        @(negedge clk);
        checkOutput("t4_occ", int'(occupancy), 0);

        // Duplicate of a stored signature frees the line once
        nextCycle();
        applyStimulus(1'b1, 1, 1'b1, 1'b0, 0, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 1, 1'b1, 1'b1, 1, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("dup_stored_present0", int'(present[0]), 1);
        checkOutput("dup_stored_present1", int'(present[1]), 1);
        nextCycle();
        idle();
        @(negedge clk);
        checkOutput("dup_stored_occ", int'(occupancy), 0);

        // Illegal signature is ignored
        nextCycle();
        applyStimulus(1'b1, 1, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("inv_present0", int'(present[0]), 0);
        checkOutput("inv_overflow0", int'(overflow[0]), 0);
        nextCycle();
        idle();
        @(negedge clk);
        checkOutput("inv_occ", int'(occupancy), 0);

        // Asynchronous reset in the middle of a cycle
        $display("[TB] mid-stream reset");
        nextCycle();
        applyStimulus(1'b1, 1, 1'b1, 1'b0, 0, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 2, 1'b1, 1'b0, 0, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 0, 1'b1, 1'b0, 0, 1'b1, 1'b0);
        nextCycle();
        idle();
        @(negedge clk);
        checkOutput("rst_pre_err", int'(overflow_err), 1);
        checkOutput("rst_pre_occ", int'(occupancy), 2);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_occ", int'(occupancy), 0);
        checkOutput("rst_async_empty", int'(empty), 1);
        checkOutput("rst_async_full", int'(full), 0);
        checkOutput("rst_async_err", int'(overflow_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        nextCycle();

        // Random traffic against the model
        $display("[TB] random phase");
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, NSIG - 1)),
                          1'($urandom_range(0, 9) != 0),
                          1'($urandom_range(0, 1)), int'($urandom_range(0, NSIG - 1)),
                          1'($urandom_range(0, 9) != 0),
                          1'($urandom_range(0, 31) == 0));
            nextCycle();
        end
        idle();
        nextCycle();
        @(negedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
